// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, state encoding and helpers for the
//                digit-serial BCD subtractor.
//  Contents    : DW, BCD_MAX, state_t + state constants, is_bcd()
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int        DW      = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_PASS1 = 2'd1;
    localparam state_t S_PASS2 = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    // True when the 4-bit code is a legal decimal digit (0..9)
    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_comp9.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_comp9
//  Description : Combinational 9's-complementer for one BCD digit.
//  Ports       : digit_in  [3:0] BCD digit
//                sel             1 = output 9 - digit_in, 0 = pass through
//                digit_out [3:0] result digit
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_comp9
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       sel,
    output logic [3:0] digit_out
);

    // Inputs are validated upstream, so 9 - d never underflows in use.
    assign digit_out = sel ? (BCD_MAX - digit_in) : digit_in;

endmodule
`default_nettype wire

// File: rtl/bcd_sub_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_sub_sequencer
//  Description : Digit-serial NDIG-digit BCD subtractor, A - B, computed by
//                10's complement one digit per clock. A second pass
//                recomplements the result when A < B, giving sign-magnitude.
//  Ports       : clk, rst_n (sync, active low)
//                start        request, accepted only in IDLE
//                a, b         packed BCD operands, digit 0 in [3:0]
//                busy         high while a pass is running
//                done         one-cycle pulse, outputs valid from here
//                result       magnitude of A - B (packed BCD)
//                neg          1 when A < B
//                err          1 when an input digit was > 9
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_sub_sequencer #(
    parameter int NDIG = 4,
    parameter int DW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NDIG*DW-1:0]  a,
    input  logic [NDIG*DW-1:0]  b,
    output logic                busy,
    output logic                done,
    output logic [NDIG*DW-1:0]  result,
    output logic                neg,
    output logic                err
);

    import bcd_pkg::*;

    localparam int              IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(NDIG - 1);

    state_t                 state;
    logic [IW-1:0]          idx;
    logic                   carry;
    logic [NDIG*DW-1:0]     a_q;
    logic [NDIG*DW-1:0]     b_q;

    logic [DW-1:0]          a_dig;
    logic [DW-1:0]          b_dig;
    logic [DW-1:0]          res_dig;
    logic [DW-1:0]          addend;
    logic [DW-1:0]          comp_in;
    logic [DW-1:0]          comp_out;
    logic                   comp_sel;
    logic [DW:0]            sum;
    logic [DW-1:0]          sum_dig;
    logic                   sum_carry;
    logic                   in_bad;

    // Operand digit selection by the shared digit index
    always_comb begin
        a_dig   = a_q[int'(idx)*DW +: DW];
        b_dig   = b_q[int'(idx)*DW +: DW];
        res_dig = result[int'(idx)*DW +: DW];
    end

    // The single complementer sees B in the first pass and the partial
    // result in the recomplement pass; complement is selected in both.
    assign comp_sel = (state == S_PASS1) || (state == S_PASS2);
    assign comp_in  = (state == S_PASS2) ? res_dig : b_dig;

    bcd_digit_comp9 u_comp9 (
        .digit_in  (comp_in),
        .sel       (comp_sel),
        .digit_out (comp_out)
    );

    // BCD digit adder: max 9 + 9 + 1 = 19 fits in DW+1 bits.
    // The recomplement pass adds nothing from A.
    always_comb begin
        addend    = (state == S_PASS1) ? a_dig : '0;
        sum       = {1'b0, addend} + {1'b0, comp_out} + {{DW{1'b0}}, carry};
        sum_dig   = sum[DW-1:0];
        sum_carry = 1'b0;
        if (sum > (DW+1)'(BCD_MAX)) begin
            sum_dig   = DW'(sum - (DW+1)'(10));
            sum_carry = 1'b1;
        end
    end

    // Input validation on the live operands at the accept edge
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd(a[i*DW +: DW]) || !is_bcd(b[i*DW +: DW])) begin
                in_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        idx    <= '0;
                        carry  <= 1'b1;
                        err    <= 1'b0;
                        neg    <= 1'b0;
                        result <= '0;
                        if (in_bad) begin
                            // done follows one edge later, from S_DONE
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_PASS1;
                        end
                    end
                end

                S_PASS1: begin
                    result[int'(idx)*DW +: DW] <= sum_dig;
                    if (idx == LAST_IDX) begin
                        if (sum_carry) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            neg   <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            // No end carry: result is the 10's complement
                            neg   <= 1'b1;
                            idx   <= '0;
                            carry <= 1'b1;
                            state <= S_PASS2;
                        end
                    end else begin
                        idx   <= idx + 1'b1;
                        carry <= sum_carry;
                    end
                end

                S_PASS2: begin
                    result[int'(idx)*DW +: DW] <= sum_dig;
                    if (idx == LAST_IDX) begin
                        // Final carry of the recomplement is discarded
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        carry <= sum_carry;
                    end
                end

                S_DONE: begin
                    // Normal paths arrive with done already set; the error
                    // path arrives with done clear and raises it here.
                    if (done) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_sub_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_sub_sequencer
//  Description : Scoreboard bench for bcd_sub_sequencer (NDIG=4) with
//                directed, hand-computed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_sub_sequencer;

    localparam int NDIG = 4;
    localparam int DW   = 4;
    localparam int W    = NDIG * DW;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         neg;
    logic         err;

    bcd_sub_sequencer #(.NDIG(NDIG), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors   = 0;
    int checks   = 0;
    int busy_cnt = 0;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         neg;
        logic         err;
        int           start_cyc;
        int           lat;
        int           busy_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"},  32'(result), 32'(e.res));
                check({e.name, "_neg"},     32'(neg),    32'(e.neg));
                check({e.name, "_err"},     32'(err),    32'(e.err));
                check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
                check({e.name, "_busy"},    32'(busy_cnt), 32'(e.busy_cyc));
            end
            busy_cnt = 0;
            @(negedge clk);
            check("done_width", 32'(done), 32'd0);
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eres, input logic eneg, input logic eerr,
                          input int elat, input int ebusy);
        exp_t e;
        @(negedge clk);
        e.name = name; e.res = eres; e.neg = eneg; e.err = eerr;
        e.start_cyc = cyc + 1; e.lat = elat; e.busy_cyc = ebusy;
        sb.push_back(e);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !done) return;
        end
        check("wait_idle_timeout", 32'd1, 32'd0);
        sb.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_done"},   32'(done),   32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_neg"},    32'(neg),    32'd0);
        check({tag, "_err"},    32'(err),    32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Basic subtraction and sign handling
        run_op("pos",   16'h0523, 16'h0187, 16'h0336, 1'b0, 1'b0, 4, 4);
        wait_idle();
        run_op("neg",   16'h0187, 16'h0523, 16'h0336, 1'b1, 1'b0, 8, 8);
        wait_idle();
        run_op("equal", 16'h4567, 16'h4567, 16'h0000, 1'b0, 1'b0, 4, 4);
        wait_idle();
        run_op("max",   16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4, 4);
        wait_idle();
        run_op("bad",   16'h05A3, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 0);
        wait_idle();

        // Start pulsed mid-PASS1 must be ignored
        run_op("busy_start", 16'h0523, 16'h0187, 16'h0336, 1'b0, 1'b0, 4, 4);
        @(negedge clk);
        a = 16'h0999; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        wait_idle();
        run_op("after_ignored", 16'h0999, 16'h0001, 16'h0998, 1'b0, 1'b0, 4, 4);
        wait_idle();

        // Reset during PASS2 aborts without a done pulse
        @(negedge clk);
        a = 16'h0187; b = 16'h0523; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        busy_cnt = 0;
        run_op("post_reset", 16'h0010, 16'h0001, 16'h0009, 1'b0, 1'b0, 4, 4);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_sub_sequencer.md
Name: bcd_sub_sequencer

Overview:
Digit-serial N-digit BCD subtractor controller computing A − B by 10's complement, one digit per clock. It shares a single 9's-complement digit unit and a single BCD digit adder across all digits. If the first pass leaves no carry, a second recomplement pass produces sign-magnitude output. It sits above the per-digit complementer as its sequencer, driving the complement-select control and digit index.

Parameters:
NDIG, 4, number of BCD digits per operand (≥1)
DW, 4, bits per BCD digit (fixed at 4; derived width = NDIG*DW)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; accepted only in IDLE
a  input  NDIG*DW  minuend, packed BCD, digit 0 in [3:0]
b  input  NDIG*DW  subtrahend, packed BCD
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result/neg/err valid from this cycle
result  output  NDIG*DW  magnitude of A − B, packed BCD
neg  output  1  1 = A < B
err  output  1  1 = an input digit was > 9

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, result=0, neg=0, err=0, digit index=0, carry=0. Reset mid-operation aborts immediately with the same values. No done is issued.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE: at the edge where start=1, capture a and b, index=0, carry=1, done=0, err=0.
  - Any digit of a or b > 9 → DONE with err=1, result=0, neg=0.
  - Otherwise → PASS1, busy=1.
- PASS1, digit i per edge: sum = a[i] + comp9(b[i]) + carry (complement select=1).
  - If sum > 9: digit = sum − 10, carry=1; else digit = sum, carry=0. Write result[i].
  - At i = NDIG−1:
    - carry_out=1 → DONE, neg=0.
    - carry_out=0 → PASS2, neg=1, index=0, carry=1.
- PASS2, digit i per edge: result[i] = BCD(comp9(result[i]) + carry), with the same decimal-carry rule.
  - After digit NDIG−1 → DONE. The final carry is discarded.
- done/busy timing: done is registered and rises on the same edge that writes the last digit, or on the edge after start for err. busy falls on that same edge.
- Latency, counting the start-accept edge as edge 0: done high after edge NDIG (A ≥ B), edge 2·NDIG (A < B), edge 1 (err).
- DONE: lasts one cycle with done=1, then → IDLE with done=0.
- result/neg/err hold until the next accepted start. A start asserted in the DONE cycle is ignored.
- start while busy is ignored. Operands may change freely after capture.
- Equal operands: PASS1 yields all-9s + 1 → carry_out=1 → result=0, neg=0. Negative zero never occurs.
- Digit arithmetic is 5-bit internal (max 9+9+1=19). Outputs are always valid BCD digits 0..9.

Decomposition:
- Package bcd_pkg holds:
  - DW=4, BCD_MAX=4'd9
  - state enum (IDLE, PASS1, PASS2, DONE) as 2-bit localparams
  - function is_bcd(digit)
- One sub-module, bcd_digit_comp9: combinational 4-bit digit plus complement-select → 9 − d when select=1, d when select=0. It is instantiated once and the sequencer muxes its input by index.
- BCD digit adder stays inline in the sequencer.

Test Plan:
- NDIG=4, a=0x0523, b=0x0187, start pulse → done after edge 4; result=0x0336, neg=0, err=0; busy high for edges 0..3.
- a=0x0187, b=0x0523 → done after edge 8; result=0x0336, neg=1; PASS2 observed for edges 5..8.
- a=b=0x4567 → result=0x0000, neg=0, done after edge 4. Also a=0x9999, b=0x0000 → result=0x9999, neg=0.
- a=0x05A3, b=0x0001 → done after edge 1, err=1, result=0, neg=0, busy never asserted.
- Start pulsed again mid-PASS1 with different operands → ignored; first result (0x0336) unchanged; next start accepted after done.
- rst_n=0 for one edge during PASS2 → all outputs 0 at next cycle, no done pulse; subsequent 0x0010−0x0001 → result=0x0009, neg=0.
